// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and loader share one memory port, CPU favoured
// with a bounded number of wins before a pending loader is forced through.
module mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 2);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            owner_q, owner_d;
    logic [WW-1:0]   ldr_wait_q, ldr_wait_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic            ldr_ack_q, ldr_ack_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic            busy_q, busy_d;
    logic            grant_ldr_c;

    // Next-state, arbitration and registered-output computation
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        owner_d     = owner_q;
        ldr_wait_d  = ldr_wait_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        grant_ldr_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    grant_ldr_c = ldr_req && (!cpu_req || ldr_wait_q == WW'(MAX_WAIT));
                    owner_d     = grant_ldr_c;
                    we_d        = grant_ldr_c ? ldr_we    : cpu_we;
                    mem_addr_d  = grant_ldr_c ? ldr_addr  : cpu_addr;
                    mem_wdata_d = grant_ldr_c ? ldr_wdata : cpu_wdata;
                    if (grant_ldr_c) begin
                        ldr_wait_d = '0;
                    end else if (ldr_req && ldr_wait_q < WW'(MAX_WAIT)) begin
                        ldr_wait_d = ldr_wait_q + WW'(1);
                    end
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d   = DONE;
                    cpu_ack_d = !owner_q;
                    ldr_ack_d = owner_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q) ldr_rdata_d = mem_rdata;
                    else         cpu_rdata_d = mem_rdata;
                    state_d   = DONE;
                    cpu_ack_d = !owner_q;
                    ldr_ack_d = owner_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            ldr_wait_q  <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            ldr_wait_q  <= ldr_wait_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected completions plus a
// latency-accurate memory model.
module tb_mem_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, ldr_req, ldr_we;
    logic [AW-1:0] cpu_addr, ldr_addr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;
    logic          cpu_ack, ldr_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return 32'h1234_5678 ^ {a[23:0], 8'h00};
    endfunction

    // Read data is only valid in the cycle RD_LAT after the mem_en cycle
    logic [DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        pipe[0] <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    typedef struct {
        bit            port;
        bit            we;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_cnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge and retire any completion against the scoreboard
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (cpu_ack || ldr_ack) begin
            ack_cnt++;
            chk("ack_exclusive", 32'(cpu_ack && ldr_ack), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port", 32'(ldr_ack), 32'(e.port));
                chk("ack_owner", 32'(owner), 32'(e.port));
                if (!e.we) chk("rdata", e.port ? ldr_rdata : cpu_rdata, e.rdata);
            end
        end
    endtask

    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input bit drop_early,
                             input int exp_lat);
        exp_t e;
        int   lat;
        e.port = port; e.we = we; e.rdata = mem_val(addr);
        exp_q.push_back(e);
        if (port) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                chk("access_mem_en", 32'(mem_en), 32'd1);
                chk("access_mem_we", 32'(mem_we), 32'(we));
                chk("access_mem_addr", mem_addr, addr);
                if (we) chk("access_mem_wdata", mem_wdata, wdata);
                if (drop_early) begin cpu_req = 1'b0; ldr_req = 1'b0; end
            end else begin
                chk("mem_en_low", 32'(mem_en), 32'd0);
            end
            if ((port && ldr_ack) || (!port && cpu_ack)) begin
                lat = i + 1;
                break;
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    logic [DW-1:0] saved;
    int            start_acks;

    initial begin
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_cpu_rdata", cpu_rdata, '0);
        chk("rst_ldr_rdata", ldr_rdata, '0);
        reset_n = 1'b1;
        tick();

        // CPU write, then loader read leaving cpu_rdata alone
        do_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 2);
        tick();
        chk("idle_after_write", 32'(busy), 32'd0);
        saved = cpu_rdata;
        do_access(1'b1, 1'b0, 32'h0, '0, 1'b0, 2 + RD_LAT);
        chk("ldr_rdata_value", ldr_rdata, 32'h1234_5678);
        chk("cpu_rdata_held", cpu_rdata, saved);
        tick();

        do_access(1'b0, 1'b0, 32'h40, '0, 1'b0, 2 + RD_LAT);
        chk("ldr_rdata_held", ldr_rdata, 32'h1234_5678);
        tick();

        // A write must not disturb either rdata register
        saved = cpu_rdata;
        do_access(1'b1, 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0, 2);
        chk("wr_keeps_cpu_rdata", cpu_rdata, saved);
        chk("wr_keeps_ldr_rdata", ldr_rdata, 32'h1234_5678);
        tick();

        // Request withdrawn in the ACCESS cycle still completes
        do_access(1'b0, 1'b1, 32'h30, 32'h5555_AAAA, 1'b1, 2);
        tick();
        chk("idle_after_drop", 32'(busy), 32'd0);

        // Both requesting continuously: C C C C L, twice
        for (int g = 0; g < 10; g++) begin
            exp_t e;
            e.port = (g % 5 == 4); e.we = 1'b1; e.rdata = '0;
            exp_q.push_back(e);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h200; ldr_wdata = 32'h2;
        start_acks = ack_cnt;
        tick();
        chk("both_first_owner", 32'(owner), 32'd0);
        for (int i = 0; i < 60 && ack_cnt < start_acks + 10; i++) tick();
        cpu_req = 1'b0; ldr_req = 1'b0;
        chk("both_grant_count", 32'(ack_cnt - start_acks), 32'd10);
        tick(); tick();

        // Reset in the middle of a CPU read abandons it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        tick();
        tick();
        chk("in_wait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("midrst_no_ack", 32'(cpu_ack), 32'd0);
        chk("midrst_cpu_rdata", cpu_rdata, '0);
        reset_n = 1'b1;
        tick();
        do_access(1'b0, 1'b0, 32'h80, '0, 1'b0, 2 + RD_LAT);
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameters, one per line:
- AW, 32, address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles after the mem_en cycle (1..4)
- MAX_WAIT, 4, CPU wins allowed against a pending loader before the loader is forced
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: loader port, same directions, widths and meanings as the CPU port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle
- busy  out  1  high in any state other than IDLE
- owner  out  1  current or last grant: 0 = CPU, 1 = loader

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE.
REQ-004 In IDLE with any request high, the block SHALL pick a winner, latch its we, addr and wdata and the owner, then go to ACCESS; with no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL grant the CPU when only cpu_req is high and the loader when only ldr_req is high.
REQ-006 When both request, the CPU SHALL win unless ldr_wait == MAX_WAIT, in which case the loader SHALL win.
REQ-007 ldr_wait SHALL increment, saturating at MAX_WAIT, on each CPU grant made while ldr_req is high, and SHALL clear on every loader grant.
REQ-008 In ACCESS the block SHALL assert mem_en=1 for exactly one cycle with mem_we, mem_addr and mem_wdata taken from the latched values.
- write: next state DONE
- read: next state WAIT
REQ-009 WAIT SHALL last exactly RD_LAT cycles using a down-counter; on its last cycle the block SHALL capture mem_rdata into the owner's rdata register and go to DONE.
REQ-010 In DONE the block SHALL pulse the owner's ack for one cycle, never the other port's ack, then return to IDLE.
REQ-011 Latency from the request being sampled in IDLE (cycle 0) SHALL be: write ack in cycle 2; read ack in cycle 2+RD_LAT.
REQ-012 Back-to-back accesses SHALL have at least one IDLE cycle between a DONE and the next ACCESS.
REQ-013 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last latched values.
REQ-014 xx_rdata SHALL hold its value until the next read completes for that port; a write SHALL NOT change either rdata.
REQ-015 A request dropped before its ack SHALL still be carried through to completion, including the ack pulse; requests are not cancelled.
REQ-016 Request inputs SHALL be sampled only in IDLE; changes on inputs in any other state SHALL have no effect on the access in flight.

Reset
REQ-017 While reset_n is low, asynchronously and at any state including mid-access, the block SHALL force:
- state IDLE; mem_en, mem_we, cpu_ack, ldr_ack and busy = 0
- owner = 0; ldr_wait and the WAIT counter = 0
- mem_addr, mem_wdata, cpu_rdata and ldr_rdata = 0
REQ-018 An access interrupted by reset SHALL be abandoned with no ack; the requester SHALL re-issue it.

Verification
REQ-019 CPU write only, addr 0x10, wdata 0xDEADBEEF -> one mem_en cycle with mem_we=1 at 0x10; cpu_ack in cycle 2; ldr_ack stays 0.
REQ-020 Loader read only, RD_LAT=2, mem_rdata=0x12345678 -> ldr_ack in cycle 4 with ldr_rdata=0x12345678; cpu_rdata unchanged.
REQ-021 Both requesting continuously, MAX_WAIT=4 -> grant order CPU, CPU, CPU, CPU, loader, then the CPU/loader pattern repeats.
REQ-022 Simultaneous request in IDLE with ldr_wait=0 -> CPU granted, owner=0, ldr_wait becomes 1.
REQ-023 reset_n driven low during WAIT of a CPU read -> next cycle IDLE, mem_en=0, no cpu_ack; after release a re-issued read completes normally.
REQ-024 cpu_req dropped in the ACCESS cycle of a write -> cpu_ack still pulses in cycle 2; the block then returns to IDLE.
